// File: rtl/hpdmc_rdcapture.sv
// DDR read-data capture: waits a programmable latency after rd_start, gathers
// BURST_LENGTH beats from IDDR2 q0/q1 pairs and emits one wide word with a valid pulse.
// Optional sticky overrun flag for dropped starts: define HPDMC_RDCAP_OVERRUN_EN.
module hpdmc_rdcapture #(
  parameter int unsigned DQ_WIDTH      = 16,
  parameter int unsigned BURST_LENGTH  = 4,
  parameter int unsigned LATENCY_WIDTH = 3,
  parameter bit          Q1_FIRST      = 1'b0
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic [LATENCY_WIDTH-1:0]         rd_latency,
  input  logic                             rd_start,
  input  logic [DQ_WIDTH-1:0]              q0,
  input  logic [DQ_WIDTH-1:0]              q1,
  output logic [DQ_WIDTH*BURST_LENGTH-1:0] rd_data,
  output logic                             rd_valid,
  output logic                             busy
`ifdef HPDMC_RDCAP_OVERRUN_EN
  ,
  output logic                             overrun
`endif
);

  localparam int unsigned BEATS  = BURST_LENGTH / 2;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DATA_W = DQ_WIDTH * BURST_LENGTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [LATENCY_WIDTH-1:0] lat_cnt;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [DATA_W-1:0]        asm_q;
  logic [DATA_W-1:0]        asm_next;
  logic [DQ_WIDTH-1:0]      first_beat;
  logic [DQ_WIDTH-1:0]      second_beat;
  int unsigned              beat_idx;

  logic last_beat;
  logic accept;
  logic wait_done;
  logic start_to_wait;
  logic rd_valid_d;
  logic busy_d;
  logic load_data;
  logic cnt_load;
  logic cnt_dec;
  logic beat_inc;

  // Control decode shared by next-state and output logic
  assign last_beat     = (state == S_CAPTURE) && (beat_cnt == BEAT_W'(BEATS - 1));
  assign accept        = rd_start && ((state == S_IDLE) || last_beat);
  assign wait_done     = (state == S_WAIT) && (lat_cnt == LATENCY_WIDTH'(1));
  assign start_to_wait = (rd_latency != '0);

  assign first_beat  = Q1_FIRST ? q1 : q0;
  assign second_beat = Q1_FIRST ? q0 : q1;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = start_to_wait ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_done) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (last_beat) begin
          if (accept) state_next = start_to_wait ? S_WAIT : S_CAPTURE;
          else        state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    rd_valid_d = 1'b0;
    busy_d     = (state_next != S_IDLE);
    load_data  = 1'b0;
    cnt_load   = accept;
    cnt_dec    = 1'b0;
    beat_inc   = 1'b0;
    case (state)
      S_WAIT:    cnt_dec = !accept;
      S_CAPTURE: begin
        rd_valid_d = last_beat;
        load_data  = last_beat;
        beat_inc   = !last_beat;
      end
      default: ;
    endcase
  end

  // Slot the current beat pair into the assembly word
  always_comb begin
    beat_idx = 32'(beat_cnt);
    asm_next = asm_q;
    asm_next[(2 * beat_idx) * DQ_WIDTH +: DQ_WIDTH]     = first_beat;
    asm_next[(2 * beat_idx + 1) * DQ_WIDTH +: DQ_WIDTH] = second_beat;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
      asm_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_valid <= rd_valid_d;
      busy     <= busy_d;
      if (cnt_load)     lat_cnt <= rd_latency;
      else if (cnt_dec) lat_cnt <= lat_cnt - LATENCY_WIDTH'(1);
      if (cnt_load)      beat_cnt <= '0;
      else if (beat_inc) beat_cnt <= beat_cnt + BEAT_W'(1);
      if (state == S_CAPTURE) asm_q <= asm_next;
      if (load_data) rd_data <= asm_next;
    end
  end

`ifdef HPDMC_RDCAP_OVERRUN_EN
  logic ignored;

  // Start seen while a burst is still mid-flight
  assign ignored = rd_start && !accept && (state != S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)      overrun <= 1'b0;
    else if (ignored) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Bench: three capture instances (BL4/Q0-first, BL4/Q1-first, BL2/DQ8) against a
// burst-level reference model; directed spec scenarios followed by random traffic.
module tb_hpdmc_rdcapture;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  rd_latency;
  logic        rd_start;
  logic [15:0] q0;
  logic [15:0] q1;

  logic [63:0] rd_data0, rd_data1;
  logic [15:0] rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic        busy0, busy1, busy2;
`ifdef HPDMC_RDCAP_OVERRUN_EN
  logic        ovr0, ovr1, ovr2;
`endif

  int cyc = 0;
  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hpdmc_rdcapture #(.DQ_WIDTH(16), .BURST_LENGTH(4), .LATENCY_WIDTH(3), .Q1_FIRST(1'b0)) dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .rd_latency(rd_latency), .rd_start(rd_start),
    .q0(q0), .q1(q1), .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
`ifdef HPDMC_RDCAP_OVERRUN_EN
    , .overrun(ovr0)
`endif
  );

  hpdmc_rdcapture #(.DQ_WIDTH(16), .BURST_LENGTH(4), .LATENCY_WIDTH(3), .Q1_FIRST(1'b1)) dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .rd_latency(rd_latency), .rd_start(rd_start),
    .q0(q0), .q1(q1), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
`ifdef HPDMC_RDCAP_OVERRUN_EN
    , .overrun(ovr1)
`endif
  );

  hpdmc_rdcapture #(.DQ_WIDTH(8), .BURST_LENGTH(2), .LATENCY_WIDTH(3), .Q1_FIRST(1'b0)) dut2 (
    .sys_clk(clk), .sys_rst(sys_rst), .rd_latency(rd_latency), .rd_start(rd_start),
    .q0(q0[7:0]), .q1(q1[7:0]), .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2)
`ifdef HPDMC_RDCAP_OVERRUN_EN
    , .overrun(ovr2)
`endif
  );

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, d, cyc, act, exp);
  endtask

  // ---------------- reference model ----------------
  localparam int NCYC = 4096;
  int beats_a [3] = '{2, 2, 1};
  int dw_a    [3] = '{16, 16, 8};
  int q1f_a   [3] = '{0, 1, 0};

  typedef struct {
    int d;
    int vcyc;
    int cs;
  } pend_t;

  pend_t       pq[$];
  logic [15:0] hq0 [NCYC];
  logic [15:0] hq1 [NCYC];
  int          lo  [3] = '{0, 0, 0};
  int          hi  [3] = '{-1, -1, -1};
  logic [63:0] exp_data [3];
  logic        exp_ovr  [3];
  bit          seen_rst = 1'b0;

  // Burst word: beat pairs laid out LSB-first, earlier beat of each pair lower
  function automatic logic [63:0] assemble(input int d, input int cs);
    logic [63:0] r, m, f, s;
    int w;
    w = dw_a[d];
    m = (64'd1 << w) - 64'd1;
    r = '0;
    for (int k = 0; k < beats_a[d]; k++) begin
      f = 64'(q1f_a[d] != 0 ? hq1[cs + k] : hq0[cs + k]) & m;
      s = 64'(q1f_a[d] != 0 ? hq0[cs + k] : hq1[cs + k]) & m;
      r = r | (f << (2 * k * w)) | (s << ((2 * k + 1) * w));
    end
    return r;
  endfunction

  logic        exp_v;
  logic        av, ab, ao;
  logic [63:0] ad;

  always @(negedge clk) begin
    if (cyc >= NCYC) begin
      $display("FAIL history_overflow cyc %0d", cyc);
      $fatal(1, "history overflow");
    end
    if (seen_rst) begin
      for (int d = 0; d < 3; d++) begin
        exp_v = 1'b0;
        for (int i = 0; i < pq.size(); i++) begin
          if (pq[i].d == d && pq[i].vcyc == cyc) begin
            exp_v = 1'b1;
            exp_data[d] = assemble(d, pq[i].cs);
            pq.delete(i);
            break;
          end
        end
        ao = 1'b0;
        case (d)
          0:       begin av = rd_valid0; ad = rd_data0;       ab = busy0; end
          1:       begin av = rd_valid1; ad = rd_data1;       ab = busy1; end
          default: begin av = rd_valid2; ad = 64'(rd_data2);  ab = busy2; end
        endcase
        chk("rd_valid", d, 64'(av), 64'(exp_v));
        chk("rd_data", d, ad, exp_data[d]);
        chk("busy", d, 64'(ab), 64'(cyc >= lo[d] && cyc <= hi[d]));
`ifdef HPDMC_RDCAP_OVERRUN_EN
        case (d)
          0:       ao = ovr0;
          1:       ao = ovr1;
          default: ao = ovr2;
        endcase
        chk("overrun", d, 64'(ao), 64'(exp_ovr[d]));
`endif
      end
    end
    // Apply this cycle's inputs to the model
    hq0[cyc] = q0;
    hq1[cyc] = q1;
    if (sys_rst) begin
      seen_rst = 1'b1;
      pq.delete();
      for (int d = 0; d < 3; d++) begin
        lo[d] = 0; hi[d] = -1; exp_data[d] = '0; exp_ovr[d] = 1'b0;
      end
    end else if (rd_start) begin
      for (int d = 0; d < 3; d++) begin
        if (!(cyc >= lo[d] && cyc <= hi[d]) || cyc == hi[d]) begin
          lo[d] = cyc + 1;
          hi[d] = cyc + int'(rd_latency) + beats_a[d];
          pq.push_back('{d, hi[d] + 1, cyc + int'(rd_latency) + 1});
        end else begin
          exp_ovr[d] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    sys_rst  = 1'b0;
    q0 = 16'($urandom);
    q1 = 16'($urandom);
  endtask

  int t;

  initial begin
    sys_rst = 1'b1; rd_start = 1'b0; rd_latency = '0; q0 = '0; q1 = '0;
    repeat (3) begin tick(); sys_rst = 1'b1; end
    tick();
    @(negedge clk);
    chk("lit_rst_busy", 0, 64'(busy0), 64'd0);
    chk("lit_rst_data", 0, rd_data0, 64'd0);

    // Basic burst, L=2
    tick(); rd_start = 1'b1; rd_latency = 3'd2; t = cyc;
    tick(); tick();
    tick(); q0 = 16'h1111; q1 = 16'h2222;
    tick(); q0 = 16'h3333; q1 = 16'h4444;
    @(negedge clk);
    chk("lit_bl2_valid", 2, 64'(rd_valid2), 64'd1);
    chk("lit_bl2_data", 2, 64'(rd_data2), 64'h2211);
    tick();
    @(negedge clk);
    chk("lit_a_valid", 0, 64'(rd_valid0), 64'd1);
    chk("lit_a_data", 0, rd_data0, 64'h4444_3333_2222_1111);
    chk("lit_q1f_data", 1, rd_data1, 64'h3333_4444_1111_2222);

    // Back-to-back: restart on final capture cycle with L=1
    tick(); rd_start = 1'b1; rd_latency = 3'd0; t = cyc;
    tick();
    tick(); rd_start = 1'b1; rd_latency = 3'd1;
    tick();
    @(negedge clk);
    chk("lit_b2b_valid1", 0, 64'(rd_valid0), 64'd1);
    chk("lit_b2b_busy", 0, 64'(busy0), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("lit_b2b_valid2", 0, 64'(rd_valid0), 64'd1);

    // Start during WAIT is dropped
    tick(); rd_start = 1'b1; rd_latency = 3'd3; t = cyc;
    tick();
    tick(); rd_start = 1'b1; rd_latency = 3'd0;
    tick();
`ifdef HPDMC_RDCAP_OVERRUN_EN
    @(negedge clk);
    chk("lit_overrun", 0, 64'(ovr0), 64'd1);
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("lit_ign_valid", 0, 64'(rd_valid0), 64'd1);
    tick(); sys_rst = 1'b1;
    tick();

    // Maximum latency on the BL=2 instance
    tick(); rd_start = 1'b1; rd_latency = 3'd7; t = cyc;
    repeat (8) tick();
    q0 = 16'h00A5; q1 = 16'h003C;
    tick();
    @(negedge clk);
    chk("lit_lmax_valid", 2, 64'(rd_valid2), 64'd1);
    chk("lit_lmax_data", 2, 64'(rd_data2), 64'h3CA5);

    // Reset in the middle of a capture
    tick(); tick();
    tick(); rd_start = 1'b1; rd_latency = 3'd0;
    tick(); sys_rst = 1'b1;
    tick();
    @(negedge clk);
    chk("lit_mid_busy", 0, 64'(busy0), 64'd0);
    chk("lit_mid_valid", 0, 64'(rd_valid0), 64'd0);
    chk("lit_mid_data", 0, rd_data0, 64'd0);

    // Random traffic
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        rd_start   = 1'b1;
        rd_latency = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 199) == 0) sys_rst = 1'b1;
    end
    repeat (12) tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
